// File: rtl/minmax_tracker.sv
// Sequential signed min/max tracker driving an external subtract-based comparator.
// Optional tie counting on the running max is enabled by defining MINMAX_TIE_CNT_EN.
module minmax_tracker #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       d,
  input  logic             last,
  output logic [3:0]       ca,
  output logic [3:0]       cb,
  input  logic             z,
  input  logic             n,
  input  logic             v,
  output logic [3:0]       min,
  output logic [3:0]       max,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic [CNT_W-1:0] ties,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, ACCEPT, CMPMIN, CMPMAX, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_nxt;
  logic [3:0] samp;
  logic       last_q;
  logic       first;
  logic       lt;

  // Signed ca < cb must include overflow (7 vs -8 corners).
  assign lt = n ^ v;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCEPT;
      ACCEPT: begin
        if (in_valid) begin
          if (first) state_nxt = last ? DONE : ACCEPT;
          else       state_nxt = CMPMIN;
        end
      end
      CMPMIN:  state_nxt = CMPMAX;
      CMPMAX:  state_nxt = last_q ? DONE : ACCEPT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ACCEPT);
    done     = (state == DONE);
    ca       = '0;
    cb       = '0;
    case (state)
      CMPMIN: begin
        ca = samp;
        cb = min;
      end
      CMPMAX: begin
        ca = max;
        cb = samp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min    <= '0;
      max    <= '0;
      cnt    <= '0;
      sat    <= 1'b0;
      samp   <= '0;
      last_q <= 1'b0;
      first  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            sat   <= 1'b0;
            first <= 1'b1;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            samp   <= d;
            last_q <= last;
            if (cnt == CNT_MAX) sat <= 1'b1;
            else                cnt <= cnt + 1'b1;
            if (first) begin
              min   <= d;
              max   <= d;
              first <= 1'b0;
            end
          end
        end
        CMPMIN: if (lt) min <= samp;
        CMPMAX: if (lt) max <= samp;
        default: ;
      endcase
    end
  end

`ifdef MINMAX_TIE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ties <= '0;
    end else begin
      case (state)
        IDLE:   if (start) ties <= '0;
        ACCEPT: if (in_valid && first) ties <= '0;
        CMPMAX: begin
          if (lt)                         ties <= '0;
          else if (z && ties != CNT_MAX)  ties <= ties + 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_z;
  assign unused_z = z;
  assign ties     = '0;
`endif

endmodule
